rf_cmd_ctrl: RTL and testbench

RF_CMD_CTRL -- requirements
Module: rf_cmd_ctrl

---
 rtl/rf_cmd_ctrl_if.sv | 30 +++
 rtl/rf_cmd_ctrl.sv | 138 +++++++++++++
 tb/tb_rf_cmd_ctrl.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rf_cmd_ctrl_if.sv
// Bundle of frame-receive, register-file and transmit handshake signals
// between the command controller (master) and its peripherals (slave).
interface rf_cmd_ctrl_if #(
  parameter int data_width    = 8,
  parameter int address_width = 4
) ();

  logic [data_width-1:0]    RX_P_Data;
  logic                     RX_D_VLD;
  logic [data_width-1:0]    RdData;
  logic                     RdData_Valid;
  logic                     TX_Busy;
  logic                     WrEn;
  logic                     RdEn;
  logic [address_width-1:0] Address;
  logic [data_width-1:0]    WrData;
  logic [data_width-1:0]    TX_P_DATA;
  logic                     TX_D_VLD;

  modport master (
    input  RX_P_Data, RX_D_VLD, RdData, RdData_Valid, TX_Busy,
    output WrEn, RdEn, Address, WrData, TX_P_DATA, TX_D_VLD
  );

  modport slave (
    output RX_P_Data, RX_D_VLD, RdData, RdData_Valid, TX_Busy,
    input  WrEn, RdEn, Address, WrData, TX_P_DATA, TX_D_VLD
  );

endinterface

// File: rtl/rf_cmd_ctrl.sv
// Byte-frame command decoder: turns WR/RD frames into register-file accesses
// and sends one reply byte (read data or an error code) per read frame.
module rf_cmd_ctrl #(
  parameter int                    data_width    = 8,
  parameter int                    address_width = 4,
  parameter logic [data_width-1:0] WR_CMD        = 8'hAA,
  parameter logic [data_width-1:0] RD_CMD        = 8'hBB,
  parameter int                    RD_TIMEOUT    = 4,
  parameter logic [data_width-1:0] ERR_CODE      = 8'hEE
) (
  input  logic          clk,
  input  logic          rst,
  rf_cmd_ctrl_if.master bus
);

  localparam int cnt_width = (RD_TIMEOUT < 1) ? 1 : $clog2(RD_TIMEOUT + 1);
  localparam logic [cnt_width-1:0] timeout_val = cnt_width'(RD_TIMEOUT);

  typedef enum logic [2:0] {
    IDLE,
    WR_ADDR,
    WR_DATA,
    WR_EXEC,
    RD_ADDR,
    RD_EXEC,
    RD_WAIT,
    TX_SEND
  } state_t;

  state_t                   state;
  logic                     wr_en;
  logic                     rd_en;
  logic                     tx_vld;
  logic [address_width-1:0] address;
  logic [data_width-1:0]    wr_data;
  logic [data_width-1:0]    tx_data;
  logic [data_width-1:0]    reply;
  logic [cnt_width-1:0]     cnt;
  logic [cnt_width-1:0]     cnt_next;

  assign cnt_next = cnt + 1'b1;

  // NOTE: every output is a flop set on the edge that enters its state, so a
  // strobe is high exactly while the FSM sits in the corresponding state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      wr_en   <= 1'b0;
      rd_en   <= 1'b0;
      tx_vld  <= 1'b0;
      address <= '0;
      wr_data <= '0;
      tx_data <= '0;
      reply   <= '0;
      cnt     <= '0;
    end else begin
      wr_en  <= 1'b0;
      rd_en  <= 1'b0;
      tx_vld <= 1'b0;

      case (state)
        IDLE: begin
          if (bus.RX_D_VLD) begin
            if (bus.RX_P_Data == WR_CMD) begin
              state <= WR_ADDR;
            end else if (bus.RX_P_Data == RD_CMD) begin
              state <= RD_ADDR;
            end
          end
        end

        WR_ADDR: begin
          if (bus.RX_D_VLD) begin
            address <= bus.RX_P_Data[address_width-1:0];
            state   <= WR_DATA;
          end
        end

        WR_DATA: begin
          if (bus.RX_D_VLD) begin
            wr_data <= bus.RX_P_Data;
            wr_en   <= 1'b1;
            state   <= WR_EXEC;
          end
        end

        WR_EXEC: begin
          state <= IDLE;
        end

        RD_ADDR: begin
          if (bus.RX_D_VLD) begin
            address <= bus.RX_P_Data[address_width-1:0];
            rd_en   <= 1'b1;
            state   <= RD_EXEC;
          end
        end

        RD_EXEC: begin
          cnt   <= '0;
          state <= RD_WAIT;
        end

        // Read data wins over a timeout landing on the same cycle.
        RD_WAIT: begin
          if (bus.RdData_Valid) begin
            reply <= bus.RdData;
            state <= TX_SEND;
          end else begin
            cnt <= cnt_next;
            if (cnt_next == timeout_val) begin
              reply <= ERR_CODE;
              state <= TX_SEND;
            end
          end
        end

        TX_SEND: begin
          if (!bus.TX_Busy) begin
            tx_data <= reply;
            tx_vld  <= 1'b1;
            state   <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.WrEn      = wr_en;
  assign bus.RdEn      = rd_en;
  assign bus.Address   = address;
  assign bus.WrData    = wr_data;
  assign bus.TX_P_DATA = tx_data;
  assign bus.TX_D_VLD  = tx_vld;

endmodule

// File: tb/tb_rf_cmd_ctrl.sv
// Self-checking bench for rf_cmd_ctrl: table of frames plus hand-written
// timing/robustness sequences, with a scoreboard on WrEn and TX_D_VLD.
module tb_rf_cmd_ctrl;

  localparam int          DW         = 8;
  localparam int          AW         = 4;
  localparam int          RD_TIMEOUT = 4;
  localparam logic [7:0]  WR_CMD     = 8'hAA;
  localparam logic [7:0]  RD_CMD     = 8'hBB;
  localparam logic [7:0]  ERR        = 8'hEE;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rf_cmd_ctrl_if #(.data_width(DW), .address_width(AW)) bus ();

  rf_cmd_ctrl #(
    .data_width(DW), .address_width(AW), .WR_CMD(WR_CMD), .RD_CMD(RD_CMD),
    .RD_TIMEOUT(RD_TIMEOUT), .ERR_CODE(ERR)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct packed {
    logic [3:0] addr;
    logic [7:0] data;
  } wr_exp_t;

  typedef struct {
    bit         is_rd;
    logic [7:0] addr_b;
    logic [7:0] data_b;
    bit         respond;
    int         busy;
    logic [3:0] exp_addr;
    logic [7:0] exp_byte;
  } vec_t;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int wr_count = 0;
  int rd_count = 0;
  int tx_count = 0;
  int wr_cyc   = 0;
  int tx_cyc   = 0;

  wr_exp_t    wr_q[$];
  logic [7:0] tx_q[$];

  logic [7:0] rf_val     = 8'h00;
  bit         rf_respond = 1'b0;
  logic       rden_prev  = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input bit ok, input string name,
                       input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Register-file model: answers one cycle after it sees RdEn.
  initial begin
    bus.RdData       = '0;
    bus.RdData_Valid = 1'b0;
    forever begin
      @(negedge clk);
      bus.RdData_Valid = rden_prev && rf_respond;
      bus.RdData       = rf_val;
      rden_prev        = bus.RdEn;
    end
  end

  // Output monitor / scoreboard consumer.
  initial begin
    wr_exp_t    e;
    logic [7:0] t;
    forever begin
      @(negedge clk);
      if (bus.WrEn === 1'b1 && bus.RdEn === 1'b1)
        check(1'b0, "wren_rden_overlap", 32'd1, 32'd0);
      if (bus.WrEn === 1'b1) begin
        wr_count++;
        wr_cyc = cyc;
        if (wr_q.size() == 0) begin
          check(1'b0, "unexpected_wren", {28'd0, bus.Address}, 32'd0);
        end else begin
          e = wr_q.pop_front();
          check(bus.Address === e.addr, "wr_address", {28'd0, bus.Address}, {28'd0, e.addr});
          check(bus.WrData === e.data, "wr_data", {24'd0, bus.WrData}, {24'd0, e.data});
        end
      end
      if (bus.RdEn === 1'b1) rd_count++;
      if (bus.TX_D_VLD === 1'b1) begin
        tx_count++;
        tx_cyc = cyc;
        if (tx_q.size() == 0) begin
          check(1'b0, "unexpected_tx", {24'd0, bus.TX_P_DATA}, 32'd0);
        end else begin
          t = tx_q.pop_front();
          check(bus.TX_P_DATA === t, "tx_data", {24'd0, bus.TX_P_DATA}, {24'd0, t});
        end
      end
    end
  end

  // Caller is at a falling edge; the byte is valid for one clock.
  task automatic send_byte(input logic [7:0] b, input int gap);
    bus.RX_P_Data = b;
    bus.RX_D_VLD  = 1'b1;
    @(negedge clk);
    bus.RX_D_VLD  = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic wait_drain(input int max_cycles, input string name);
    for (int i = 0; i < max_cycles && (wr_q.size() != 0 || tx_q.size() != 0); i++)
      @(negedge clk);
    check(wr_q.size() == 0 && tx_q.size() == 0, name,
          32'(wr_q.size() + tx_q.size()), 32'd0);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  vec_t vecs[7];

  initial begin
    int w0, r0, t0, c0;

    vecs[0] = '{is_rd:0, addr_b:8'h05, data_b:8'h3C, respond:0, busy:0,  exp_addr:4'h5, exp_byte:8'h3C};
    vecs[1] = '{is_rd:1, addr_b:8'h02, data_b:8'h81, respond:1, busy:0,  exp_addr:4'h2, exp_byte:8'h81};
    vecs[2] = '{is_rd:0, addr_b:8'hF3, data_b:8'hA7, respond:0, busy:0,  exp_addr:4'h3, exp_byte:8'hA7};
    vecs[3] = '{is_rd:1, addr_b:8'h07, data_b:8'h12, respond:0, busy:0,  exp_addr:4'h7, exp_byte:8'hEE};
    vecs[4] = '{is_rd:1, addr_b:8'h0E, data_b:8'h5A, respond:1, busy:10, exp_addr:4'hE, exp_byte:8'h5A};
    vecs[5] = '{is_rd:0, addr_b:8'h1F, data_b:8'h00, respond:0, busy:0,  exp_addr:4'hF, exp_byte:8'h00};
    vecs[6] = '{is_rd:1, addr_b:8'h3B, data_b:8'hC3, respond:1, busy:2,  exp_addr:4'hB, exp_byte:8'hC3};

    rst           = 1'b1;
    bus.RX_P_Data = '0;
    bus.RX_D_VLD  = 1'b0;
    bus.TX_Busy   = 1'b0;
    repeat (2) @(negedge clk);

    check(bus.WrEn === 1'b0 && bus.RdEn === 1'b0 && bus.TX_D_VLD === 1'b0, "reset_strobes",
          {29'd0, bus.WrEn, bus.RdEn, bus.TX_D_VLD}, 32'd0);
    check(bus.Address === 4'h0, "reset_address", {28'd0, bus.Address}, 32'd0);
    check(bus.WrData === 8'h00, "reset_wrdata", {24'd0, bus.WrData}, 32'd0);
    check(bus.TX_P_DATA === 8'h00, "reset_txdata", {24'd0, bus.TX_P_DATA}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Table-driven frames.
    foreach (vecs[i]) begin
      w0 = wr_count; r0 = rd_count; t0 = tx_count;
      if (!vecs[i].is_rd) begin
        wr_q.push_back('{addr: vecs[i].exp_addr, data: vecs[i].exp_byte});
        send_byte(WR_CMD, 1);
        send_byte(vecs[i].addr_b, 1);
        send_byte(vecs[i].data_b, 1);
      end else begin
        tx_q.push_back(vecs[i].exp_byte);
        rf_val     = vecs[i].data_b;
        rf_respond = vecs[i].respond;
        send_byte(RD_CMD, 1);
        if (vecs[i].busy > 0) bus.TX_Busy = 1'b1;
        send_byte(vecs[i].addr_b, 0);
        repeat (vecs[i].busy) @(negedge clk);
        bus.TX_Busy = 1'b0;
      end
      wait_drain(40, "vec_drain");
      repeat (2) @(negedge clk);
      check(bus.Address === vecs[i].exp_addr, "vec_address_hold",
            {28'd0, bus.Address}, {28'd0, vecs[i].exp_addr});
      check(wr_count - w0 == (vecs[i].is_rd ? 0 : 1), "vec_wren_pulses", 32'(wr_count - w0), 32'(vecs[i].is_rd ? 0 : 1));
      check(rd_count - r0 == (vecs[i].is_rd ? 1 : 0), "vec_rden_pulses", 32'(rd_count - r0), 32'(vecs[i].is_rd ? 1 : 0));
      check(tx_count - t0 == (vecs[i].is_rd ? 1 : 0), "vec_tx_pulses", 32'(tx_count - t0), 32'(vecs[i].is_rd ? 1 : 0));
    end

    // Junk byte in IDLE, then a write and a read back-to-back.
    w0 = wr_count; r0 = rd_count; t0 = tx_count;
    send_byte(8'h55, 3);
    check(wr_count == w0 && rd_count == r0 && tx_count == t0, "junk_ignored",
          32'(wr_count + rd_count + tx_count), 32'(w0 + r0 + t0));
    wr_q.push_back('{addr: 4'h9, data: 8'h6D});
    tx_q.push_back(8'h5E);
    rf_val = 8'h5E; rf_respond = 1'b1;
    send_byte(WR_CMD, 1);
    send_byte(8'h09, 1);
    c0 = cyc;
    send_byte(8'h6D, 1);
    send_byte(RD_CMD, 1);
    send_byte(8'h0A, 1);
    wait_drain(40, "b2b_drain");
    check(wr_cyc == c0 + 1, "wr_latency", 32'(wr_cyc - c0), 32'd1);

    // Timeout: reply EE RD_TIMEOUT+1 cycles after entering RD_WAIT.
    rf_respond = 1'b0;
    tx_q.push_back(ERR);
    send_byte(RD_CMD, 1);
    c0 = cyc;
    send_byte(8'h07, 1);
    wait_drain(40, "timeout_drain");
    check(tx_cyc == c0 + 2 + RD_TIMEOUT + 1, "timeout_latency",
          32'(tx_cyc - c0), 32'(2 + RD_TIMEOUT + 1));

    // Back-pressure: TX_Busy high for 10 cycles.
    rf_respond = 1'b1; rf_val = 8'hC9;
    tx_q.push_back(8'hC9);
    send_byte(RD_CMD, 1);
    t0 = tx_count;
    c0 = cyc;
    bus.TX_Busy = 1'b1;
    send_byte(8'h0D, 0);
    repeat (9) @(negedge clk);
    check(tx_count == t0, "no_tx_while_busy", 32'(tx_count - t0), 32'd0);
    bus.TX_Busy = 1'b0;
    wait_drain(40, "busy_drain");
    repeat (3) @(negedge clk);
    check(tx_cyc == c0 + 11, "busy_release_latency", 32'(tx_cyc - c0), 32'd11);
    check(tx_count - t0 == 1, "busy_single_pulse", 32'(tx_count - t0), 32'd1);
    check(bus.TX_P_DATA === 8'hC9, "tx_data_hold", {24'd0, bus.TX_P_DATA}, 32'hC9);

    // A byte arriving during WR_EXEC is dropped.
    w0 = wr_count; r0 = rd_count;
    wr_q.push_back('{addr: 4'h2, data: 8'hB4});
    wr_q.push_back('{addr: 4'h1, data: 8'h22});
    send_byte(WR_CMD, 1);
    send_byte(8'h02, 1);
    send_byte(8'hB4, 0);
    send_byte(RD_CMD, 1);
    send_byte(WR_CMD, 1);
    send_byte(8'h01, 1);
    send_byte(8'h22, 1);
    wait_drain(40, "drop_drain");
    check(wr_count - w0 == 2 && rd_count == r0, "drop_in_exec",
          32'(wr_count - w0), 32'd2);

    // Reset mid-write frame aborts it.
    w0 = wr_count;
    send_byte(WR_CMD, 1);
    send_byte(8'h04, 1);
    pulse_reset();
    check(bus.Address === 4'h0, "reset_clears_address", {28'd0, bus.Address}, 32'd0);
    send_byte(8'h11, 1);
    repeat (5) @(negedge clk);
    check(wr_count == w0, "reset_aborts_write", 32'(wr_count - w0), 32'd0);
    check(bus.WrData === 8'h00, "reset_clears_wrdata", {24'd0, bus.WrData}, 32'd0);

    // Reset while waiting in TX_SEND aborts the reply.
    t0 = tx_count;
    rf_respond = 1'b1; rf_val = 8'h44;
    send_byte(RD_CMD, 1);
    bus.TX_Busy = 1'b1;
    send_byte(8'h03, 1);
    repeat (4) @(negedge clk);
    pulse_reset();
    check(bus.TX_P_DATA === 8'h00, "reset_clears_txdata", {24'd0, bus.TX_P_DATA}, 32'd0);
    bus.TX_Busy = 1'b0;
    repeat (6) @(negedge clk);
    check(tx_count == t0, "reset_aborts_tx", 32'(tx_count - t0), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "simulation time limit");
  end

endmodule
